bt_pipe_in_source: RTL and testbench

Block-throttled pipe-in transmitter: generates BTPipeIn-style transfers (`ep_blockstrobe` followed by a burst of `ep_write` words) that carry a selectable test pattern. It is the source-side counterpart of `pipe_in_check` and lets the pipe test design run on-chip loopback without host traffic. It sits in the `okClk` domain. Its outputs connect directly to the `pipe_in_check` write/data/ready inputs, or to any consumer with the same handshake.

---
 rtl/pipe_test_pkg.sv | 30 +++
 rtl/pipe_pattern_gen.sv | 59 +++++
 rtl/bt_pipe_in_source.sv | 170 +++++++++++++++++
 tb/tb_bt_pipe_in_source.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_test_pkg.sv
// Shared definitions for the pipe test source and checkers.
//   - pipe_state_e : transfer FSM state encoding
//   - PAT_*        : pattern select codes (codes 4..7 behave as fixed)
//   - LFSR_TAPS    : feedback taps of the 32-bit LFSR (bits 31, 21, 1, 0)
//   - lfsr_next    : one LFSR step
package pipe_test_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitReady,
    StStrobe,
    StBurst,
    StGap,
    StDone
  } pipe_state_e;

  localparam logic [2:0] PAT_COUNTER = 3'd0;
  localparam logic [2:0] PAT_LFSR    = 3'd1;
  localparam logic [2:0] PAT_WALK1   = 3'd2;
  localparam logic [2:0] PAT_FIXED   = 3'd3;

  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
  // An all-zero LFSR state would lock up, so a zero seed is replaced.
  localparam logic [31:0] LFSR_ZERO_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] d);
    return {d[30:0], ^(d & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// Test-pattern register shared by the pipe source and checkers.
// Ports:
//   okClk, reset : clock, synchronous active-high reset
//   load         : capture pattern/seed/fixed and present the first word
//   advance      : step to the next word (ignored when load is high)
//   pattern      : pattern select (PAT_* codes, 4..7 = fixed)
//   seed         : counter / LFSR start value
//   fixed        : word used by the fixed patterns
//   word         : current pattern word
module pipe_pattern_gen
  import pipe_test_pkg::*;
(
  input  logic        okClk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [2:0]  pattern,
  input  logic [31:0] seed,
  input  logic [31:0] fixed,
  output logic [31:0] word
);

  logic [2:0]  pat_q, pat_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    pat_d  = pat_q;
    word_d = word_q;
    if (load) begin
      pat_d = pattern;
      case (pattern)
        PAT_COUNTER: word_d = seed;
        PAT_LFSR:    word_d = (seed == 32'h0) ? LFSR_ZERO_SEED : seed;
        PAT_WALK1:   word_d = 32'h0000_0001;
        default:     word_d = fixed;
      endcase
    end else if (advance) begin
      case (pat_q)
        PAT_COUNTER: word_d = word_q + 32'h1;
        PAT_LFSR:    word_d = lfsr_next(word_q);
        PAT_WALK1:   word_d = {word_q[30:0], word_q[31]};
        default:     word_d = word_q;
      endcase
    end
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      pat_q  <= PAT_COUNTER;
      word_q <= 32'h0;
    end else begin
      pat_q  <= pat_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/bt_pipe_in_source.sv
// Block-throttled pipe-in transmitter: emits a blockstrobe followed by a burst of
// up to BLOCK_WORDS write words, repeated until 'length' words carrying the
// selected test pattern have been sent.
// Ports:
//   okClk, reset      : clock, synchronous active-high reset
//   start             : begin a transfer (ignored unless idle)
//   length            : words to send (0 = immediate done)
//   pattern/seed/fixed_pattern : pattern configuration, sampled on start
//   ep_ready          : consumer can take one full block
//   ep_write/ep_blockstrobe/ep_dataout : registered pipe-in handshake
//   busy, done        : transfer in progress / end-of-transfer pulse
//   words_sent        : words written since the last accepted start
module bt_pipe_in_source
  import pipe_test_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 256,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned LEN_W       = 32
) (
  input  logic             okClk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [2:0]       pattern,
  input  logic [31:0]      seed,
  input  logic [31:0]      fixed_pattern,
  input  logic             ep_ready,
  output logic             ep_write,
  output logic             ep_blockstrobe,
  output logic [31:0]      ep_dataout,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_sent
);

  localparam int unsigned BlkW = $clog2(BLOCK_WORDS + 1);
  localparam logic [BlkW-1:0] BlkFull = BlkW'(BLOCK_WORDS);
  localparam logic [7:0] GapLast = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  pipe_state_e      state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;     // words not yet scheduled
  logic [BlkW-1:0]  blk_q, blk_d;     // words scheduled in the current block
  logic [7:0]       gap_q, gap_d;

  logic             write_q, write_d;
  logic             strobe_q, strobe_d;
  logic [31:0]      data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] words_q, words_d;

  logic             start_ok;
  logic [31:0]      gen_word;

  assign start_ok = (state_q == StIdle) && start;

  // The generator always holds the next word to send; it steps as that word is
  // captured into ep_dataout.
  pipe_pattern_gen u_gen (
    .okClk   (okClk),
    .reset   (reset),
    .load    (start_ok && (length != '0)),
    .advance (write_d),
    .pattern (pattern),
    .seed    (seed),
    .fixed   (fixed_pattern),
    .word    (gen_word)
  );

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      blk_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      blk_q   <= blk_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    blk_d   = blk_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length == '0) begin
            state_d = StDone;
          end else begin
            state_d = StWaitReady;
            rem_d   = length;
          end
        end
      end
      StWaitReady: begin
        blk_d = '0;
        if (ep_ready) state_d = StStrobe;
      end
      StStrobe, StBurst: begin
        // Final-transfer check precedes the block-full check so a transfer that
        // ends exactly on a block boundary goes straight to done.
        if (rem_q == '0) begin
          state_d = StDone;
        end else if (blk_q == BlkFull) begin
          if (GAP_CYCLES == 0) begin
            state_d = StWaitReady;
          end else begin
            state_d = StGap;
            gap_d   = GapLast;
          end
        end else begin
          state_d = StBurst;
          rem_d   = rem_q - 1'b1;
          blk_d   = blk_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == 8'd0) state_d = StWaitReady;
        else               gap_d   = gap_q - 8'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they describe.
  always_comb begin
    write_d  = (state_d == StBurst);
    strobe_d = (state_d == StStrobe);
    busy_d   = (state_d == StWaitReady) || (state_d == StStrobe) ||
               (state_d == StBurst)     || (state_d == StGap);
    done_d   = (state_d == StDone);
    data_d   = write_d ? gen_word : data_q;
    words_d  = words_q;
    if (start_ok)     words_d = '0;
    else if (write_d) words_d = words_q + 1'b1;
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      write_q  <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      words_q  <= '0;
    end else begin
      write_q  <= write_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      words_q  <= words_d;
    end
  end

  assign ep_write       = write_q;
  assign ep_blockstrobe = strobe_q;
  assign ep_dataout     = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign words_sent     = words_q;

endmodule

// File: tb/tb_bt_pipe_in_source.sv
// Directed bench for bt_pipe_in_source with BLOCK_WORDS=4, GAP_CYCLES=4.
// Every negedge is labelled by a running cycle number; the monitor logs writes,
// strobes and done pulses with their labels for the checks below.
module tb_bt_pipe_in_source;

  localparam int unsigned BW  = 4;
  localparam int unsigned GAP = 4;

  logic        okClk = 1'b0;
  logic        reset, start, ep_ready;
  logic [31:0] length, seed, fixed_pattern;
  logic [2:0]  pattern;
  logic        ep_write, ep_blockstrobe, busy, done;
  logic [31:0] ep_dataout, words_sent;

  bt_pipe_in_source #(
    .BLOCK_WORDS (BW),
    .GAP_CYCLES  (GAP),
    .LEN_W       (32)
  ) dut (
    .okClk          (okClk),
    .reset          (reset),
    .start          (start),
    .length         (length),
    .pattern        (pattern),
    .seed           (seed),
    .fixed_pattern  (fixed_pattern),
    .ep_ready       (ep_ready),
    .ep_write       (ep_write),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_dataout     (ep_dataout),
    .busy           (busy),
    .done           (done),
    .words_sent     (words_sent)
  );

  always #5 okClk = ~okClk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0] wr_data[$];
  int          wr_lbl[$];
  int          stb_lbl[$];
  int          done_lbl[$];
  int          both_cnt;
  int          done_busy_cnt;

  always @(negedge okClk) begin
    cyc++;
    if (ep_write) begin
      wr_data.push_back(ep_dataout);
      wr_lbl.push_back(cyc);
    end
    if (ep_blockstrobe) stb_lbl.push_back(cyc);
    if (ep_write && ep_blockstrobe) both_cnt++;
    if (done) begin
      done_lbl.push_back(cyc);
      if (busy) done_busy_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic clear_log();
    wr_data.delete();
    wr_lbl.delete();
    stb_lbl.delete();
    done_lbl.delete();
    both_cnt      = 0;
    done_busy_cnt = 0;
  endtask

  // Returns the label of the cycle right after the edge that samples start.
  task automatic start_xfer(input logic [31:0] len, input logic [2:0] pat,
                            input logic [31:0] sd, input logic [31:0] fx, output int lbl);
    @(posedge okClk);
    #1;
    start = 1'b1; length = len; pattern = pat; seed = sd; fixed_pattern = fx;
    lbl = cyc + 2;
    @(posedge okClk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_lbl.size() == 0 && n < budget) begin
      @(negedge okClk);
      #1;
      n++;
    end
    check_eq("done_seen", done_lbl.size(), 1);
    tick();
    tick();
  endtask

  task automatic wait_writes(input int cnt, input int budget);
    int n;
    n = 0;
    while (wr_data.size() < cnt && n < budget) begin
      @(negedge okClk);
      #1;
      n++;
    end
    check_eq("writes_reached", wr_data.size() >= cnt, 1);
  endtask

  task automatic check_counter_data(input string tag, input int cnt, input logic [31:0] sd);
    logic [31:0] e;
    check_eq({tag, "_nwr"}, wr_data.size(), cnt);
    e = sd;
    for (int i = 0; i < cnt; i++) begin
      check_eq({tag, "_data"}, wr_data[i], e);
      e = e + 32'h1;
    end
  endtask

  initial begin
    int          lbl;
    int          r;
    logic [31:0] exp_w;
    logic [31:0] lfsr_exp[4];

    reset = 1'b1; start = 1'b0; ep_ready = 1'b1;
    length = '0; pattern = '0; seed = '0; fixed_pattern = '0;
    clear_log();
    repeat (3) tick();
    check_eq("rst_write",  ep_write, 0);
    check_eq("rst_strobe", ep_blockstrobe, 0);
    check_eq("rst_data",   ep_dataout, 0);
    check_eq("rst_busy",   busy, 0);
    check_eq("rst_done",   done, 0);
    check_eq("rst_words",  words_sent, 0);
    reset = 1'b0;
    tick();
    check_eq("idle_busy", busy, 0);

    // Two full blocks of a counter starting at 0x100.
    clear_log();
    start_xfer(32'd8, 3'd0, 32'h100, 32'h0, lbl);
    check_eq("t1_busy_k1", busy, 1);
    wait_done(200);
    check_counter_data("t1", 8, 32'h100);
    check_eq("t1_nstb", stb_lbl.size(), 2);
    check_eq("t1_stb0_lat", stb_lbl[0] - lbl, 1);
    check_eq("t1_wr0_lat", wr_lbl[0] - lbl, 2);
    check_eq("t1_b2b0", wr_lbl[3] - wr_lbl[0], 3);
    // GAP_CYCLES idle cycles plus the WAIT_READY cycle that samples ep_ready.
    check_eq("t1_idle", stb_lbl[1] - wr_lbl[3] - 1, GAP + 1);
    check_eq("t1_stb1_wr", wr_lbl[4] - stb_lbl[1], 1);
    check_eq("t1_b2b1", wr_lbl[7] - wr_lbl[4], 3);
    check_eq("t1_done_lat", done_lbl[0] - wr_lbl[7], 1);
    check_eq("t1_done_busy", done_busy_cnt, 0);
    check_eq("t1_overlap", both_cnt, 0);
    check_eq("t1_words", words_sent, 8);
    check_eq("t1_busy_end", busy, 0);

    // Short final block, counter wrapping through 2^32.
    clear_log();
    start_xfer(32'd6, 3'd0, 32'hFFFF_FFFE, 32'h0, lbl);
    wait_done(200);
    check_counter_data("t2", 6, 32'hFFFF_FFFE);
    check_eq("t2_nstb", stb_lbl.size(), 2);
    check_eq("t2_short", wr_lbl[5] - stb_lbl[1], 2);
    check_eq("t2_words", words_sent, 6);

    // Ready gating.
    clear_log();
    ep_ready = 1'b0;
    start_xfer(32'd4, 3'd0, 32'h10, 32'h0, lbl);
    repeat (20) tick();
    check_eq("t3_no_stb", stb_lbl.size(), 0);
    check_eq("t3_no_wr", wr_data.size(), 0);
    check_eq("t3_busy", busy, 1);
    r = cyc;
    ep_ready = 1'b1;
    wait_writes(2, 50);
    ep_ready = 1'b0;
    wait_done(100);
    check_eq("t3_stb_lbl", stb_lbl[0] - r, 2);
    check_counter_data("t3", 4, 32'h10);
    ep_ready = 1'b1;

    // LFSR with zero seed.
    clear_log();
    lfsr_exp[0] = 32'h1; lfsr_exp[1] = 32'h3; lfsr_exp[2] = 32'h6; lfsr_exp[3] = 32'hD;
    start_xfer(32'd4, 3'd1, 32'h0, 32'h0, lbl);
    wait_done(100);
    check_eq("t4_nwr", wr_data.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("t4_lfsr", wr_data[i], lfsr_exp[i]);

    // Walking one across the wrap.
    clear_log();
    start_xfer(32'd33, 3'd2, 32'h1234, 32'h0, lbl);
    wait_done(600);
    check_eq("t5_nwr", wr_data.size(), 33);
    exp_w = 32'h1;
    for (int i = 0; i < 33; i++) begin
      check_eq("t5_walk", wr_data[i], exp_w);
      exp_w = {exp_w[30:0], exp_w[31]};
    end
    check_eq("t5_nstb", stb_lbl.size(), 9);

    // Fixed pattern, code 3 and alias code 6.
    clear_log();
    start_xfer(32'd5, 3'd3, 32'h77, 32'hA5A5_5A5A, lbl);
    wait_done(100);
    check_eq("t6_nwr", wr_data.size(), 5);
    for (int i = 0; i < 5; i++) check_eq("t6_fixed", wr_data[i], 32'hA5A5_5A5A);
    clear_log();
    start_xfer(32'd2, 3'd6, 32'h77, 32'h0BAD_F00D, lbl);
    wait_done(100);
    check_eq("t6_alias0", wr_data[0], 32'h0BAD_F00D);
    check_eq("t6_alias1", wr_data[1], 32'h0BAD_F00D);

    // Reset on the third write of a burst.
    clear_log();
    start_xfer(32'd8, 3'd0, 32'h200, 32'h0, lbl);
    wait_writes(3, 50);
    reset = 1'b1;
    tick();
    check_eq("t7_write",  ep_write, 0);
    check_eq("t7_strobe", ep_blockstrobe, 0);
    check_eq("t7_data",   ep_dataout, 0);
    check_eq("t7_busy",   busy, 0);
    check_eq("t7_done",   done, 0);
    check_eq("t7_words",  words_sent, 0);
    reset = 1'b0;
    clear_log();
    repeat (10) tick();
    check_eq("t7_no_done", done_lbl.size(), 0);
    check_eq("t7_no_wr", wr_data.size(), 0);
    start_xfer(32'd2, 3'd0, 32'h200, 32'h0, lbl);
    wait_done(100);
    check_counter_data("t7r", 2, 32'h200);

    // Zero length.
    clear_log();
    start_xfer(32'd0, 3'd0, 32'h5, 32'h0, lbl);
    check_eq("t8_done_k1", done, 1);
    check_eq("t8_busy_k1", busy, 0);
    tick();
    check_eq("t8_done_once", done, 0);
    repeat (6) tick();
    check_eq("t8_done_lbl", done_lbl[0] - lbl, 0);
    check_eq("t8_ndone", done_lbl.size(), 1);
    check_eq("t8_no_wr", wr_data.size(), 0);
    check_eq("t8_no_stb", stb_lbl.size(), 0);

    // Start while busy is ignored.
    clear_log();
    start_xfer(32'd6, 3'd0, 32'h300, 32'h0, lbl);
    wait_writes(2, 50);
    start_xfer(32'd2, 3'd3, 32'h999, 32'hDEAD, r);
    wait_done(200);
    repeat (4) tick();
    check_counter_data("t9", 6, 32'h300);
    check_eq("t9_ndone", done_lbl.size(), 1);
    check_eq("t9_words", words_sent, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
